// File: rtl/decode_stream_pkg.sv
// -----------------------------------------------------------------------------
// decode_stream_pkg
// Shared constants for the LZS bit-stream aligner and its consumer.
//   STREAM_W  : width of the look-ahead window presented to the decoder
//   W_*       : consume widths used by the decoder for each token class
//   END_MARK  : 9-bit end-of-stream marker as it appears at the window top
// -----------------------------------------------------------------------------
package decode_stream_pkg;

    localparam int STREAM_W = 13;

    // Consume widths issued by decode_ctl on stream_ack.
    localparam logic [3:0] W_LIT   = 4'd9;
    localparam logic [3:0] W_OFF7  = 4'd9;
    localparam logic [3:0] W_OFF11 = 4'd13;
    localparam logic [3:0] W_LEN   = 4'd2;
    localparam logic [3:0] W_LEN3  = 4'd4;

    localparam logic [8:0] END_MARK = 9'h180;

    typedef logic [STREAM_W-1:0] stream_word_t;

endpackage : decode_stream_pkg

// File: rtl/decode_stream_if.sv
// -----------------------------------------------------------------------------
// decode_stream_if
// Bundles the FIFO-side and decoder-side signals of the bit-stream aligner.
//   fi_data/fi_empty/fi_rd  : first-word-fall-through FIFO head and pop
//   src_done                : no further words will enter the FIFO
//   stream_*                : 13-bit window, qualifiers and consume handshake
//   err                     : sticky protocol-error flag
// Modports:
//   master : the aligner (consumes FIFO, produces the stream window)
//   slave  : its environment (FIFO + decoder)
// -----------------------------------------------------------------------------
interface decode_stream_if #(
    parameter int IN_W = 32
);
    import decode_stream_pkg::*;

    logic [IN_W-1:0] fi_data;
    logic            fi_empty;
    logic            fi_rd;
    logic            src_done;
    stream_word_t    stream_data;
    logic            stream_valid;
    logic            stream_done;
    logic [3:0]      stream_width;
    logic            stream_ack;
    logic            err;

    modport master (
        input  fi_data,
        input  fi_empty,
        input  src_done,
        input  stream_width,
        input  stream_ack,
        output fi_rd,
        output stream_data,
        output stream_valid,
        output stream_done,
        output err
    );

    modport slave (
        output fi_data,
        output fi_empty,
        output src_done,
        output stream_width,
        output stream_ack,
        input  fi_rd,
        input  stream_data,
        input  stream_valid,
        input  stream_done,
        input  err
    );

endinterface : decode_stream_if

// File: rtl/decode_stream_shifter.sv
// -----------------------------------------------------------------------------
// decode_shifter
// Combinational datapath of the aligner: drops the consumed bits off the top
// of the bit buffer and drops a freshly popped word in directly below the
// bits that remain.
// Ports:
//   buf_in   in  BUF_W  current buffer, MSB = oldest stream bit
//   shift    in  4      bits consumed this cycle (0 when no ack)
//   post     in  CNT_W  bits remaining after the consume
//   word     in  IN_W   popped FIFO word, first stream bit in MSB
//   insert   in  1      a word is popped this cycle
//   buf_out  out BUF_W  next buffer contents
// -----------------------------------------------------------------------------
module decode_shifter #(
    parameter int BUF_W = 64,
    parameter int IN_W  = 32,
    parameter int CNT_W = 7
) (
    input  logic [BUF_W-1:0] buf_in,
    input  logic [3:0]       shift,
    input  logic [CNT_W-1:0] post,
    input  logic [IN_W-1:0]  word,
    input  logic             insert,
    output logic [BUF_W-1:0] buf_out
);

    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] placed;

    // Bits below cnt are always zero, so shifting past the valid region
    // naturally leaves an all-zero buffer.
    assign shifted = buf_in << shift;

    // Word starts at the top and slides down to sit just under the remaining
    // bits: it occupies [BUF_W-1-post -: IN_W]. The refill condition keeps
    // post <= BUF_W-IN_W, so nothing falls off the bottom.
    assign placed = {word, {(BUF_W-IN_W){1'b0}}} >> post;

    assign buf_out = shifted | (insert ? placed : '0);

endmodule : decode_shifter

// File: rtl/decode_stream.sv
// -----------------------------------------------------------------------------
// decode_stream
// Bit-stream aligner in front of decode_ctl. Pops packed LZS words from an
// FWFT FIFO into a bit buffer, always shows the next 13 stream bits MSB-aligned
// and consumes stream_width bits per stream_ack. Once the source is finished
// and the FIFO is empty, the last (<13) bits are flushed out zero-padded, and
// stream_done rises when everything has been consumed.
// Parameters:
//   IN_W   input word width (8/16/32)
//   BUF_W  bit-buffer width, at least IN_W+13
//   BSWAP  1: byte-reverse fi_data before use (little-endian packing)
// Ports:
//   clk    in  clock, all state on the rising edge
//   rst_n  in  asynchronous reset, active low
//   ce     in  enable for FIFO reads; acks are honoured regardless
//   bus    --  decode_stream_if master: FIFO head/pop, src_done, stream window,
//              consume handshake and sticky err
// -----------------------------------------------------------------------------
module decode_stream
    import decode_stream_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int BUF_W = 64,
    parameter int BSWAP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    decode_stream_if.master  bus
);

    localparam int CNT_W = $clog2(BUF_W + 1);

    // ---------------------------------------------------------------- state
    logic [BUF_W-1:0] buf_reg, buf_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             done_seen_reg;
    logic             err_reg, err_next;

    // ------------------------------------------------------ input word order
    logic [IN_W-1:0] word;

    generate
        if (BSWAP != 0) begin : g_bswap
            for (genvar gi = 0; gi < IN_W/8; gi++) begin : g_byte
                assign word[gi*8 +: 8] = bus.fi_data[IN_W-8-gi*8 +: 8];
            end
        end else begin : g_nobswap
            assign word = bus.fi_data;
        end
    endgenerate

    // ------------------------------------------------------ window qualifiers
    logic flush;
    logic valid;

    // Flush shows a short tail once nothing more can arrive; a pending word
    // in the FIFO defers it, so late src_done still lets the FIFO drain first.
    assign flush = done_seen_reg & bus.fi_empty & (cnt_reg != '0);
    assign valid = (cnt_reg >= CNT_W'(STREAM_W)) | flush;

    // -------------------------------------------------------------- consume
    logic             ack_ok;
    logic [3:0]       w_eff;
    logic             over;
    logic [CNT_W-1:0] post;
    logic             rd;

    // An ack against an invalid window is ignored (and flagged).
    assign ack_ok = bus.stream_ack & valid;
    assign w_eff  = ack_ok ? bus.stream_width : 4'd0;
    assign over   = CNT_W'(w_eff) > cnt_reg;
    assign post   = over ? '0 : cnt_reg - CNT_W'(w_eff);

    // --------------------------------------------------------------- refill
    // Refill decision looks at the post-consume count so a consume and a pop
    // can share a cycle; that is what sustains one ack per cycle. Reset
    // masks the pop so the FIFO is never drained while held in reset.
    assign rd = rst_n & ce & ~bus.fi_empty & (post <= CNT_W'(BUF_W - IN_W));

    assign cnt_next = post + (rd ? CNT_W'(IN_W) : '0);
    assign err_next = err_reg | (bus.stream_ack & ~valid) | over;

    decode_shifter #(
        .BUF_W (BUF_W),
        .IN_W  (IN_W),
        .CNT_W (CNT_W)
    ) u_shifter (
        .buf_in  (buf_reg),
        .shift   (w_eff),
        .post    (post),
        .word    (word),
        .insert  (rd),
        .buf_out (buf_next)
    );

    // --------------------------------------------------------- state update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_reg       <= '0;
            cnt_reg       <= '0;
            done_seen_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            buf_reg       <= buf_next;
            cnt_reg       <= cnt_next;
            done_seen_reg <= done_seen_reg | bus.src_done;
            err_reg       <= err_next;
        end
    end

    // -------------------------------------------------------------- outputs
    assign bus.fi_rd        = rd;
    assign bus.stream_data  = buf_reg[BUF_W-1 -: STREAM_W];
    assign bus.stream_valid = valid;
    assign bus.stream_done  = done_seen_reg & bus.fi_empty & (cnt_reg == '0) & ~rd;
    assign bus.err          = err_reg;

endmodule : decode_stream

// File: tb/tb_decode_stream.sv
module tb_decode_stream;
    import decode_stream_pkg::*;

    localparam int IN_W  = 32;
    localparam int BUF_W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;
    always #5 clk = ~clk;

    decode_stream_if #(.IN_W(IN_W)) bus ();
    decode_stream_if #(.IN_W(IN_W)) bus_sw ();

    decode_stream #(.IN_W(IN_W), .BUF_W(BUF_W), .BSWAP(0)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .bus(bus));

    decode_stream #(.IN_W(IN_W), .BUF_W(BUF_W), .BSWAP(1)) dut_sw (
        .clk(clk), .rst_n(rst_n), .ce(ce), .bus(bus_sw));

    // ------------------------------------------------------------ bench state
    int n_tests = 0;
    int n_fail  = 0;

    logic       ack = 1'b0;
    logic [3:0] width = 4'd0;
    logic       src_done = 1'b0;

    logic [31:0] fifo_q[$];   // words waiting in the external FIFO
    bit          mq[$];       // reference bit stream held by the aligner, [0] = oldest
    bit          m_done = 1'b0;
    bit          m_err  = 1'b0;

    bit          e_valid, e_rd, e_done;
    logic [12:0] e_data;

    typedef struct {
        bit       ack;
        int       w;
        bit       exp_valid;
        bit       exp_rd;
    } vec_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic bit model_valid();
        return (mq.size() >= 13) || (m_done && fifo_q.size() == 0 && mq.size() != 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        logic [31:0] head;
        head = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
        bus.fi_data         = head;
        bus.fi_empty        = (fifo_q.size() == 0);
        bus.src_done        = src_done;
        bus.stream_ack      = ack;
        bus.stream_width    = width;
        bus_sw.fi_data      = bswap32(head);
        bus_sw.fi_empty     = (fifo_q.size() == 0);
        bus_sw.src_done     = src_done;
        bus_sw.stream_ack   = ack;
        bus_sw.stream_width = width;
    endtask

    // Compute expectations from the reference stream, then compare on the
    // falling edge (both byte orders must show the same stream).
    task automatic step_pre();
        int cnt, w, post;
        bit empty;
        if (!rst_n) begin
            mq.delete();
            m_done = 1'b0;
            m_err  = 1'b0;
        end
        drive_inputs();
        cnt   = mq.size();
        empty = (fifo_q.size() == 0);
        e_valid = rst_n && ((cnt >= 13) || (m_done && empty && cnt != 0));
        for (int i = 0; i < 13; i++)
            e_data[12-i] = (i < cnt) ? mq[i] : 1'b0;
        w    = (ack && e_valid) ? int'(width) : 0;
        post = (w > cnt) ? 0 : cnt - w;
        e_rd   = rst_n && ce && !empty && (post <= BUF_W - IN_W);
        e_done = rst_n && m_done && empty && (cnt == 0) && !e_rd;
        @(negedge clk);
        chk("valid",     32'(bus.stream_valid),    32'(e_valid));
        chk("data",      32'(bus.stream_data),     32'(e_data));
        chk("fi_rd",     32'(bus.fi_rd),           32'(e_rd));
        chk("done",      32'(bus.stream_done),     32'(e_done));
        chk("err",       32'(bus.err),             32'(m_err));
        chk("sw_valid",  32'(bus_sw.stream_valid), 32'(e_valid));
        chk("sw_data",   32'(bus_sw.stream_data),  32'(e_data));
        chk("sw_fi_rd",  32'(bus_sw.fi_rd),        32'(e_rd));
    endtask

    // Advance the reference stream across the rising edge.
    task automatic step_post();
        logic [31:0] word;
        int w;
        @(posedge clk);
        if (rst_n) begin
            if (ack && !e_valid) begin
                m_err = 1'b1;
            end else if (ack) begin
                w = int'(width);
                if (w > mq.size()) begin
                    m_err = 1'b1;
                    mq.delete();
                end else begin
                    repeat (w) void'(mq.pop_front());
                end
            end
            if (e_rd) begin
                word = fifo_q.pop_front();
                for (int i = 31; i >= 0; i--) mq.push_back(word[i]);
            end
            if (src_done) m_done = 1'b1;
        end
        #1;
    endtask

    task automatic step();
        step_pre();
        step_post();
    endtask

    task automatic do_reset();
        fifo_q.delete();
        ack = 1'b0; width = 4'd0; src_done = 1'b0;
        rst_n = 1'b0;
        step_pre();
        chk("rst_valid", 32'(bus.stream_valid), 32'd0);
        chk("rst_err",   32'(bus.err),          32'd0);
        step_post();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        int   k;
        bit   got_v;
        int   pushed;

        tbl = '{
            '{0, 0, 0, 1}, '{0, 0, 1, 1},                 // two pops: 0 -> 32 -> 64
            '{1, 13, 1, 0}, '{1, 4, 1, 0}, '{1, 2, 1, 0}, // 64 -> 51 -> 47 -> 45
            '{1, 13, 1, 1},                               // cnt 45, post 32: refill -> 64
            '{1, 9, 1, 0}, '{1, 9, 1, 0},                 // -> 55 -> 46
            '{1, 13, 1, 0},                               // cnt 46, post 33: no refill
            '{1, 2, 1, 1},                                // 33 -> 31 + 32 = 63
            '{1, 13, 1, 0}, '{1, 2, 1, 0}, '{1, 4, 1, 0}, '{1, 4, 1, 0} // -> 40
        };

        drive_inputs();
        repeat (2) @(posedge clk);
        #1;

        // ---------------------------------------------------- reset state
        step_pre();
        chk("init_valid", 32'(bus.stream_valid), 32'd0);
        chk("init_data",  32'(bus.stream_data),  32'd0);
        chk("init_fi_rd", 32'(bus.fi_rd),        32'd0);
        step_post();
        rst_n = 1'b1;

        // ------------------------------------------- first word, both orders
        fifo_q.push_back(32'hA5000000);
        ce = 1'b1;
        step_pre();
        chk("t2_fi_rd", 32'(bus.fi_rd), 32'd1);
        chk("t2_sw_fi_rd", 32'(bus_sw.fi_rd), 32'd1);
        step_post();
        step_pre();
        chk("t2_valid",   32'(bus.stream_valid),   32'd1);
        chk("t2_data",    32'(bus.stream_data),    32'h14A0);
        chk("t2_sw_data", 32'(bus_sw.stream_data), 32'h14A0);
        step_post();
        $display("[TB] first-word latency and byte-swap sequence done");

        // ------------------------------ consume/refill table, then reset at 40
        do_reset();
        repeat (4) fifo_q.push_back($urandom);
        ce = 1'b1;
        for (int i = 0; i < 14; i++) begin
            ack = tbl[i].ack;
            width = 4'(tbl[i].w);
            step_pre();
            chk($sformatf("tbl%0d_valid", i), 32'(bus.stream_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_fi_rd", i), 32'(bus.fi_rd),        32'(tbl[i].exp_rd));
            $display("[TB] vector %0d ack=%0d w=%0d valid=%0d fi_rd=%0d",
                     i, tbl[i].ack, tbl[i].w, bus.stream_valid, bus.fi_rd);
            step_post();
        end
        ack = 1'b0; width = 4'd0;
        fifo_q.push_back(32'hDEADBEEF);
        chk("pre_rst_valid", 32'(bus.stream_valid), 32'd1);
        rst_n = 1'b0;
        step_pre();
        chk("midrst_valid", 32'(bus.stream_valid), 32'd0);
        chk("midrst_fi_rd", 32'(bus.fi_rd),        32'd0);
        chk("midrst_data",  32'(bus.stream_data),  32'd0);
        step_post();
        rst_n = 1'b1;
        step_pre();
        chk("postrst_fi_rd", 32'(bus.fi_rd), 32'd1);
        step_post();
        step_pre();
        chk("postrst_data", 32'(bus.stream_data), 32'(13'h1BD5));
        step_post();
        $display("[TB] mid-stream reset sequence done");

        // ------------------------------------------ end marker flush + error
        do_reset();
        fifo_q.push_back({16'h1234, END_MARK, 7'h0});
        ce = 1'b1; src_done = 1'b1;
        step();
        src_done = 1'b0;
        ack = 1'b1; width = W_LEN3;
        repeat (4) step();
        width = W_LIT;
        step_pre();
        chk("eom_valid", 32'(bus.stream_valid), 32'd1);
        chk("eom_mark",  32'(bus.stream_data[12:4]), 32'(END_MARK));
        step_post();
        width = W_LEN;
        step_pre();
        chk("flush7_valid", 32'(bus.stream_valid), 32'd1);
        chk("flush7_done",  32'(bus.stream_done),  32'd0);
        step_post();
        width = W_OFF11;
        step_pre();
        chk("flush5_valid", 32'(bus.stream_valid), 32'd1);
        chk("flush5_err",   32'(bus.err),          32'd0);
        step_post();
        ack = 1'b0;
        step_pre();
        chk("over_err",   32'(bus.err),          32'd1);
        chk("over_done",  32'(bus.stream_done),  32'd1);
        chk("over_valid", 32'(bus.stream_valid), 32'd0);
        step_post();
        ack = 1'b1; width = W_LEN;
        step();
        ack = 1'b0;
        step_pre();
        chk("sticky_err", 32'(bus.err), 32'd1);
        step_post();
        do_reset();
        step_pre();
        chk("cleared_err", 32'(bus.err), 32'd0);
        step_post();
        $display("[TB] flush and error sequence done");

        // ------------------------------- sustained width-9 acks, 1000 words
        do_reset();
        ce = 1'b1;
        fifo_q.push_back($urandom);
        fifo_q.push_back($urandom);
        pushed = 2;
        k = 0;
        got_v = 1'b0;
        while (!got_v && k < 8) begin
            step_pre();
            got_v = bus.stream_valid;
            step_post();
            k++;
        end
        chk("t3_first_valid_cycle", 32'(k), 32'd2);
        ack = 1'b1; width = W_LIT;
        for (int c = 0; c < 4000; c++) begin
            while (fifo_q.size() < 2 && pushed < 1000) begin
                fifo_q.push_back($urandom);
                pushed++;
            end
            if (fifo_q.size() == 0) break;
            step_pre();
            chk("t3_sustain", 32'(bus.stream_valid), 32'd1);
            step_post();
        end
        chk("t3_all_words_used", 32'(pushed + fifo_q.size()), 32'd1000);
        chk("t3_fifo_drained",   32'(fifo_q.size()),          32'd0);
        ack = 1'b0;
        $display("[TB] sustained ack run done, %0d words", pushed);

        // --------------------------------------- randomized mixed traffic
        for (int chunk = 0; chunk < 6; chunk++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                ce = ($urandom % 4) != 0;
                if (c < 300 && ($urandom % 3) == 0 && fifo_q.size() < 4)
                    fifo_q.push_back($urandom);
                src_done = (c == 300);
                if (model_valid()) ack = ($urandom % 2) != 0;
                else               ack = ($urandom % 60) == 0;
                case ($urandom % 5)
                    0: width = W_LEN;
                    1: width = W_LEN3;
                    2: width = W_LIT;
                    3: width = W_OFF11;
                    default: width = 4'($urandom % 16);
                endcase
                step();
            end
            src_done = 1'b0;
            ack = 1'b0;
            $display("[TB] random chunk %0d done, err=%0d done=%0d", chunk, bus.err, bus.stream_done);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_decode_stream
